muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit covering the RV32M-style op set.
// Works on operand magnitudes for DATA_WIDTH cycles, then applies sign correction in one cycle.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [2:0]            op_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic                  flush_i
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            op_q, op_d;
    logic                  aNeg_q, aNeg_d;
    logic                  bNeg_q, bNeg_d;
    logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
    logic [DATA_WIDTH-1:0] accHi_q, accHi_d;
    logic [DATA_WIDTH-1:0] accLo_q, accLo_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic                  accept;
    logic                  inASigned, inBSigned;
    logic                  inANeg, inBNeg;
    logic [DATA_WIDTH-1:0] inAMag, inBMag;
    logic                  divZero, divOverflow;
    logic [DATA_WIDTH:0]   mulSum, divShift, divDiff;
    logic [2*DATA_WIDTH-1:0] prodMag, prodFix;
    logic [DATA_WIDTH-1:0] quoFix, remFix, fixResult;

    assign accept  = valid_i & (state_q == S_IDLE);
    assign ready_o = (state_q == S_IDLE);
    assign valid_o = (state_q == S_DONE);
    assign res_o   = valid_o ? result_q : '0;

    // Signedness per op: op[2] selects divide, op[0] marks its unsigned variants.
    assign inASigned = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
    assign inBSigned = op_i[2] ? ~op_i[0] : ~op_i[1];
    assign inANeg    = inASigned & a_i[DATA_WIDTH-1];
    assign inBNeg    = inBSigned & b_i[DATA_WIDTH-1];
    assign inAMag    = inANeg ? -a_i : a_i;
    assign inBMag    = inBNeg ? -b_i : b_i;

    assign divZero     = op_i[2] & (b_i == '0);
    assign divOverflow = op_i[2] & ~op_i[0] & (a_i == MOST_NEG) & (b_i == '1);

    // Multiply keeps the multiplier in accLo and shifts the partial product in from the top.
    assign mulSum = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opnd_q} : '0);

    // Divide shifts the dividend out of accLo into the partial remainder in accHi.
    assign divShift = {accHi_q, accLo_q[DATA_WIDTH-1]};
    assign divDiff  = divShift - {1'b0, opnd_q};

    assign prodMag = {accHi_q, accLo_q};
    assign prodFix = (aNeg_q ^ bNeg_q) ? -prodMag : prodMag;
    assign quoFix  = (aNeg_q ^ bNeg_q) ? -accLo_q : accLo_q;
    assign remFix  = aNeg_q ? -accHi_q : accHi_q;

    always_comb begin
        fixResult = remFix;
        case (op_q)
            3'b000:                 fixResult = prodFix[DATA_WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fixResult = prodFix[2*DATA_WIDTH-1:DATA_WIDTH];
            3'b100, 3'b101:         fixResult = quoFix;
            default:                fixResult = remFix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        aNeg_d   = aNeg_q;
        bNeg_d   = bNeg_q;
        opnd_d   = opnd_q;
        accHi_d  = accHi_q;
        accLo_d  = accLo_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = op_i;
                    aNeg_d = inANeg;
                    bNeg_d = inBNeg;
                    if (divZero) begin
                        result_d = op_i[1] ? a_i : '1;
                        state_d  = S_DONE;
                    end else if (divOverflow) begin
                        result_d = op_i[1] ? '0 : a_i;
                        state_d  = S_DONE;
                    end else begin
                        accHi_d = '0;
                        opnd_d  = op_i[2] ? inBMag : inAMag;
                        accLo_d = op_i[2] ? inAMag : inBMag;
                        cnt_d   = CNT_LOAD;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (op_q[2]) begin
                    if (!divDiff[DATA_WIDTH]) begin
                        accHi_d = divDiff[DATA_WIDTH-1:0];
                        accLo_d = {accLo_q[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        accHi_d = divShift[DATA_WIDTH-1:0];
                        accLo_d = {accLo_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end else begin
                    accHi_d = mulSum[DATA_WIDTH:1];
                    accLo_d = {mulSum[0], accLo_q[DATA_WIDTH-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fixResult;
                state_d  = S_DONE;
            end
            default: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // Flush outranks the result handshake; in IDLE there is nothing to abort.
        if (flush_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            aNeg_q   <= 1'b0;
            bNeg_q   <= 1'b0;
            opnd_q   <= '0;
            accHi_q  <= '0;
            accLo_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            aNeg_q   <= aNeg_d;
            bNeg_q   <= bNeg_d;
            opnd_q   <= opnd_d;
            accHi_q  <= accHi_d;
            accLo_q  <= accLo_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results are queued at issue and checked when valid_o rises.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_i, b_i;
    logic [2:0]  op_i;
    logic        valid_i, ready_o, valid_o, ready_i, flush_i;
    logic [31:0] res_o;

    logic [31:0] expResQ[$];
    int          expLatQ[$];
    string       tagQ[$];

    int compareCount = 0;
    int mismatchCount = 0;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_i     (a_i),
        .b_i     (b_i),
        .op_i    (op_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .res_o   (res_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .flush_i (flush_i)
    );

    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            mismatchCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Independent reference built on 64-bit native arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sbu;
        logic [63:0] p;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        sbu = {32'b0, b};
        p   = '0;
        case (op)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * sbu; return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'b101: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 32'h0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 32'h0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int refLat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 32'h0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
        return 34;
    endfunction

    // Called at a negedge; returns #1 after the accepting edge with inputs scrambled.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input int expLat, input string tag);
        int waitCycles = 0;
        while (!ready_o && waitCycles < 100) begin
            @(negedge clk);
            waitCycles++;
        end
        compare({tag, " ready_o before issue"}, 32'(ready_o), 32'd1);
        expResQ.push_back(expRes);
        expLatQ.push_back(expLat);
        tagQ.push_back(tag);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        a_i     = $urandom;
        b_i     = $urandom;
        op_i    = 3'($urandom);
    endtask

    task automatic checkOutput(input int holdCycles);
        logic [31:0] expRes, held;
        int expLat;
        string tag;
        int lat = 0;
        expRes = expResQ.pop_front();
        expLat = expLatQ.pop_front();
        tag    = tagQ.pop_front();
        do begin
            @(negedge clk);
            lat++;
        end while (!valid_o && lat < 100);
        compare({tag, " latency"}, 32'(lat), 32'(expLat));
        compare({tag, " result"}, res_o, expRes);
        compare({tag, " ready_o in DONE"}, 32'(ready_o), 32'd0);
        held = res_o;
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            compare({tag, " hold valid_o"}, 32'(valid_o), 32'd1);
            compare({tag, " hold res_o"}, res_o, held);
            compare({tag, " hold ready_o"}, 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        compare({tag, " idle valid_o"}, 32'(valid_o), 32'd0);
        compare({tag, " idle ready_o"}, 32'(ready_o), 32'd1);
        compare({tag, " idle res_o"}, res_o, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic sawValid;
        logic [2:0] rop;
        logic [31:0] ra, rb;

        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
        a_i = '0; b_i = '0; op_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compare("reset ready_o", 32'(ready_o), 32'd1);
        compare("reset valid_o", 32'(valid_o), 32'd0);
        compare("reset res_o", res_o, 32'h0);

        applyStimulus(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul 7*-3"); checkOutput(0);
        applyStimulus(3'b001, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, "mulh 7*-3"); checkOutput(0);
        applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu max*max"); checkOutput(0);
        // -1 times (2^32-1) is -(2^32-1): high word all ones.
        applyStimulus(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu -1*max"); checkOutput(0);
        applyStimulus(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "div -7/2"); checkOutput(0);
        applyStimulus(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, "rem -7/2"); checkOutput(0);
        applyStimulus(3'b101, 32'd100, 32'd7, 32'd14, 34, "divu 100/7"); checkOutput(0);
        applyStimulus(3'b111, 32'd100, 32'd7, 32'd2, 34, "remu 100/7"); checkOutput(0);
        applyStimulus(3'b101, 32'd100, 32'd0, 32'hFFFFFFFF, 1, "divu 100/0"); checkOutput(0);
        applyStimulus(3'b111, 32'd100, 32'd0, 32'd100, 1, "remu 100/0"); checkOutput(0);
        applyStimulus(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div ovf"); checkOutput(0);
        applyStimulus(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, "rem ovf"); checkOutput(0);
        applyStimulus(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, "backpressure mul"); checkOutput(5);

        // Flush at the tenth CALC cycle.
        op_i = 3'b011; a_i = 32'd123; b_i = 32'd456; valid_i = 1'b1;
        @(posedge clk); #1; valid_i = 1'b0;
        sawValid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (valid_o) sawValid = 1'b1;
        end
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        compare("flush ready_o", 32'(ready_o), 32'd1);
        compare("flush valid_o", 32'(valid_o), 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_o) sawValid = 1'b1;
        end
        compare("flush no valid pulse", 32'(sawValid), 32'd0);
        applyStimulus(3'b000, 32'd3, 32'd5, 32'd15, 34, "mul 3*5 after flush"); checkOutput(0);

        // Reset at the fifth CALC cycle.
        op_i = 3'b000; a_i = 32'd9; b_i = 32'd9; valid_i = 1'b1;
        @(posedge clk); #1; valid_i = 1'b0;
        sawValid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (valid_o) sawValid = 1'b1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        compare("midop reset ready_o", 32'(ready_o), 32'd1);
        compare("midop reset valid_o", 32'(valid_o), 32'd0);
        compare("midop reset res_o", res_o, 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_o) sawValid = 1'b1;
        end
        compare("midop reset no valid pulse", 32'(sawValid), 32'd0);

        for (int i = 0; i < 12; i++) begin
            rop = 3'($urandom);
            ra  = $urandom;
            rb  = (i % 3 == 0) ? $urandom_range(0, 15) : $urandom;
            if (i == 4) rb = 32'h0;
            applyStimulus(rop, ra, rb, refModel(rop, ra, rb), refLat(rop, ra, rb),
                          $sformatf("rand%0d op%0d a=%08h b=%08h", i, rop, ra, rb));
            checkOutput(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
